// File: rtl/clock_pkg.sv
// Shared types and constants for the clock mode controller.
//   state_t          : 2-bit mode encoding (STOP/RUN/SET_MIN/SET_HR)
//   TICK_DIV_DEFAULT : default clk cycles per seconds tick
package clock_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_HR  = 2'd3
  } state_t;

  // True for the two time-setting modes
  function automatic logic is_set_state(input state_t s);
    return (s == ST_SET_MIN) || (s == ST_SET_HR);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter and tick cleared)
//   tick : registered one-cycle pulse, high the cycle after count == TICK_DIV-1
module tick_prescaler
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and register the terminal-count compare as tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clock_ctrl_fsm.sv
// Mode controller for the digital clock: turns button pulses into
// STOP/RUN/SET_MIN/SET_HR modes, strobes and the seconds tick.
//   clk, rst          : clock, synchronous active-high reset
//   start_stop_p      : start/stop button pulse
//   mode_p            : mode button pulse
//   inc_p             : increment button pulse
//   clear_p           : clear-seconds button pulse
//   tick              : one-cycle pulse every TICK_DIV cycles
//   en                : high while in RUN
//   sec_clr           : clear seconds strobe
//   min_inc, hr_inc   : minute / hour increment strobes
//   blink             : display enable for the field being set
//   state             : current mode encoding
module clock_ctrl_fsm
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop_p,
  input  logic       mode_p,
  input  logic       inc_p,
  input  logic       clear_p,
  output logic       tick,
  output logic       en,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       blink,
  output logic [1:0] state
);

  state_t state_q;
  state_t state_n;
  logic   sec_clr_n;
  logic   min_inc_n;
  logic   hr_inc_n;
  logic   blink_n;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign state = state_q;

  // Next state and next registered outputs; only the highest-priority pulse acts
  always_comb begin
    state_n   = state_q;
    sec_clr_n = 1'b0;
    min_inc_n = 1'b0;
    hr_inc_n  = 1'b0;
    blink_n   = 1'b0;

    if (clear_p) begin
      // Time may not be altered while running
      if (state_q != ST_RUN) sec_clr_n = 1'b1;
    end else if (start_stop_p) begin
      state_n = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end else if (mode_p) begin
      case (state_q)
        ST_STOP: begin
          state_n   = ST_SET_MIN;
          sec_clr_n = 1'b1;
        end
        ST_SET_MIN: state_n = ST_SET_HR;
        ST_SET_HR:  state_n = ST_STOP;
        default: ;
      endcase
    end else if (inc_p) begin
      case (state_q)
        ST_SET_MIN: min_inc_n = 1'b1;
        ST_SET_HR:  hr_inc_n  = 1'b1;
        default: ;
      endcase
    end

    // Entry into a set mode forces blink on, even over a coincident tick
    if (is_set_state(state_n)) begin
      if (state_n != state_q) blink_n = 1'b1;
      else if (tick)          blink_n = ~blink;
      else                    blink_n = blink;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
      en      <= 1'b0;
      sec_clr <= 1'b0;
      min_inc <= 1'b0;
      hr_inc  <= 1'b0;
      blink   <= 1'b0;
    end else begin
      state_q <= state_n;
      en      <= (state_n == ST_RUN);
      sec_clr <= sec_clr_n;
      min_inc <= min_inc_n;
      hr_inc  <= hr_inc_n;
      blink   <= blink_n;
    end
  end

endmodule

// File: tb/tb_clock_ctrl_fsm.sv
// Directed bench for clock_ctrl_fsm with TICK_DIV=4.
module tb_clock_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop_p = 1'b0;
  logic       mode_p = 1'b0;
  logic       inc_p = 1'b0;
  logic       clear_p = 1'b0;
  logic       tick;
  logic       en;
  logic       sec_clr;
  logic       min_inc;
  logic       hr_inc;
  logic       blink;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int k = 0;         // non-reset edges since last reset
  int en_tick = 0;   // cycles observed with en && tick

  clock_ctrl_fsm #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_stop_p (start_stop_p),
    .mode_p       (mode_p),
    .inc_p        (inc_p),
    .clear_p      (clear_p),
    .tick         (tick),
    .en           (en),
    .sec_clr      (sec_clr),
    .min_inc      (min_inc),
    .hr_inc       (hr_inc),
    .blink        (blink),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Apply one cycle of button pulses, then check every output after the edge
  task automatic step(input logic ss, input logic m, input logic i, input logic c,
                      input logic [1:0] es, input logic esc, input logic emi,
                      input logic ehi, input logic eb);
    start_stop_p = ss;
    mode_p       = m;
    inc_p        = i;
    clear_p      = c;
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    #1;
    start_stop_p = 1'b0;
    mode_p       = 1'b0;
    inc_p        = 1'b0;
    clear_p      = 1'b0;
    if (en && tick) en_tick++;
    check("state",   32'(state),   32'(es));
    check("en",      32'(en),      32'(es == 2'd1));
    check("sec_clr", 32'(sec_clr), 32'(esc));
    check("min_inc", 32'(min_inc), 32'(emi));
    check("hr_inc",  32'(hr_inc),  32'(ehi));
    check("blink",   32'(blink),   32'(eb));
    check("tick",    32'(tick),    32'((k != 0) && (k % 4 == 0)));
  endtask

  task automatic idle(input logic [1:0] es, input logic eb, input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0, 0, es, 0, 0, 0, eb);
  endtask

  initial begin
    // Power-on reset
    rst = 1'b1;
    idle(2'd0, 1'b0, 2);
    rst = 1'b0;

    // Run/stop: start at k=10, stop at k=30; ticks at 12,16,20,24,28 while running
    idle(2'd0, 1'b0, 9);
    step(1, 0, 0, 0, 2'd1, 0, 0, 0, 0);            // k=10
    idle(2'd1, 1'b0, 19);                          // k=11..29
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);            // k=30
    check("en_tick_count", 32'(en_tick), 32'd5);

    // Ignored in RUN
    step(1, 0, 0, 0, 2'd1, 0, 0, 0, 0);            // k=31
    step(0, 1, 0, 0, 2'd1, 0, 0, 0, 0);            // k=32 mode ignored
    step(0, 0, 1, 0, 2'd1, 0, 0, 0, 0);            // k=33 inc ignored
    step(0, 0, 0, 1, 2'd1, 0, 0, 0, 0);            // k=34 clear ignored
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);            // k=35 stop
    step(1, 0, 0, 0, 2'd1, 0, 0, 0, 0);            // k=36 run
    step(0, 0, 0, 0, 2'd1, 0, 0, 0, 0);            // k=37

    // Reset mid-RUN for 3 cycles, overriding a coincident start/stop pulse
    rst = 1'b1;
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    idle(2'd0, 1'b0, 2);
    rst = 1'b0;

    // Set sequence: visible ticks at k=4,8,12,...; blink toggles at edges 5,9,13,...
    idle(2'd0, 1'b0, 2);                           // k=1,2
    step(0, 1, 0, 0, 2'd2, 1, 0, 0, 1);            // k=3  STOP->SET_MIN, sec_clr
    step(0, 0, 1, 0, 2'd2, 0, 1, 0, 1);            // k=4
    step(0, 0, 1, 0, 2'd2, 0, 1, 0, 0);            // k=5  blink toggles
    step(0, 0, 1, 0, 2'd2, 0, 1, 0, 0);            // k=6
    step(0, 1, 0, 0, 2'd3, 0, 0, 0, 1);            // k=7  ->SET_HR
    step(0, 0, 1, 0, 2'd3, 0, 0, 1, 1);            // k=8
    step(0, 0, 1, 0, 2'd3, 0, 0, 1, 0);            // k=9  blink toggles
    idle(2'd3, 1'b0, 3);                           // k=10..12
    step(0, 0, 0, 0, 2'd3, 0, 0, 0, 1);            // k=13 blink toggles
    step(0, 1, 0, 0, 2'd0, 0, 0, 0, 0);            // k=14 ->STOP

    // Simultaneous pulses in SET_MIN: clear wins, others dropped
    step(0, 1, 0, 0, 2'd2, 1, 0, 0, 1);            // k=15 ->SET_MIN
    step(1, 1, 0, 1, 2'd2, 1, 0, 0, 1);            // k=16 only sec_clr
    step(1, 0, 0, 0, 2'd1, 0, 0, 0, 0);            // k=17 ->RUN, blink off

    // SET_MIN entry coinciding with a tick (visible after k=20)
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 0);            // k=18 ->STOP
    idle(2'd0, 1'b0, 2);                           // k=19,20
    step(0, 1, 0, 0, 2'd2, 1, 0, 0, 1);            // k=21 entry wins
    idle(2'd2, 1'b1, 3);                           // k=22..24
    step(0, 0, 0, 0, 2'd2, 0, 0, 0, 0);            // k=25 toggles on next tick
    step(0, 0, 0, 1, 2'd2, 1, 0, 0, 0);            // k=26 clear in SET_MIN
    step(0, 1, 0, 0, 2'd3, 0, 0, 0, 1);            // k=27 ->SET_HR
    step(0, 1, 0, 0, 2'd0, 0, 0, 0, 0);            // k=28 ->STOP
    step(0, 0, 0, 1, 2'd0, 1, 0, 0, 0);            // k=29 clear in STOP
    step(0, 0, 1, 0, 2'd0, 0, 0, 0, 0);            // k=30 inc ignored in STOP

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
